// File: rtl/cacheline_mem_arbiter.sv
// Round-robin arbiter sharing one cacheline memory port between the icache (read-only)
// and the dcache (read / write-back); each grant is held until the memory responds.
module cacheline_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              m_read,
   output logic              m_write,
   output logic [ADDR_W-1:0] m_address,
   output logic [LINE_W-1:0] m_wdata,
   input  logic [LINE_W-1:0] m_rdata,
   input  logic              m_resp,
   output logic [31:0]       conflict_cnt
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } state_t;

   localparam logic LAST_I = 1'b0;
   localparam logic LAST_D = 1'b1;

   state_t      state_reg, state_next;
   logic        last_served_reg, last_served_next;
   logic [31:0] conflict_cnt_reg;
   logic        conflict;
   logic        i_req, d_req;

   assign i_req = i_read;
   assign d_req = d_read | d_write;

   // Read data is broadcast; only the response pulses are steered.
   assign i_rdata      = m_rdata;
   assign d_rdata      = m_rdata;
   assign conflict_cnt = conflict_cnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg        <= IDLE;
         last_served_reg  <= LAST_D;
         conflict_cnt_reg <= '0;
      end else begin
         state_reg       <= state_next;
         last_served_reg <= last_served_next;
         if (conflict) begin
            conflict_cnt_reg <= conflict_cnt_reg + 32'd1;
         end
      end
   end

   always_comb begin
      state_next       = state_reg;
      last_served_next = last_served_reg;
      m_read           = 1'b0;
      m_write          = 1'b0;
      m_address        = i_address;
      m_wdata          = d_wdata;
      i_resp           = 1'b0;
      d_resp           = 1'b0;
      conflict         = 1'b0;

      case (state_reg)
         IDLE: begin
            // A stray m_resp here is deliberately ignored.
            if (i_req && d_req) begin
               state_next = (last_served_reg == LAST_D) ? SERVE_I : SERVE_D;
            end else if (i_req) begin
               state_next = SERVE_I;
            end else if (d_req) begin
               state_next = SERVE_D;
            end
         end
         SERVE_I: begin
            m_read    = i_read;
            m_address = i_address;
            conflict  = d_req;
            if (!i_req) begin
               state_next = IDLE;
            end else if (m_resp) begin
               i_resp     = 1'b1;
               state_next = d_req ? SERVE_D : IDLE;
            end
         end
         SERVE_D: begin
            // Write-back wins if both qualifiers are (illegally) raised together.
            m_write   = d_write;
            m_read    = d_read & ~d_write;
            m_address = d_address;
            conflict  = i_req;
            if (!d_req) begin
               state_next = IDLE;
            end else if (m_resp) begin
               d_resp     = 1'b1;
               state_next = i_req ? SERVE_I : IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      if (state_next == SERVE_I) begin
         last_served_next = LAST_I;
      end else if (state_next == SERVE_D) begin
         last_served_next = LAST_D;
      end
   end

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Directed bench for cacheline_mem_arbiter: drives after each rising edge, samples
// on the falling edge, and compares against hand-computed values.
module tb_cacheline_mem_arbiter;

   localparam int ADDR_W = 32;
   localparam int LINE_W = 256;

   logic              clk = 1'b0;
   logic              rst;
   logic              i_read;
   logic [ADDR_W-1:0] i_address;
   logic [LINE_W-1:0] i_rdata;
   logic              i_resp;
   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_address;
   logic [LINE_W-1:0] d_wdata;
   logic [LINE_W-1:0] d_rdata;
   logic              d_resp;
   logic              m_read;
   logic              m_write;
   logic [ADDR_W-1:0] m_address;
   logic [LINE_W-1:0] m_wdata;
   logic [LINE_W-1:0] m_rdata;
   logic              m_resp;
   logic [31:0]       conflict_cnt;

   int checks = 0;
   int errors = 0;

   cacheline_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .m_read(m_read), .m_write(m_write), .m_address(m_address), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_resp(m_resp),
      .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      i_read = 0; i_address = '0; d_read = 0; d_write = 0; d_address = '0;
      d_wdata = '0; m_rdata = '0; m_resp = 0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++;
      if ({m_read, m_write, i_resp, d_resp} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_outputs: got rd/wr/iresp/dresp=%b required 0000", {m_read, m_write, i_resp, d_resp});
      end
      checks++;
      if (conflict_cnt !== 32'd0) begin
         errors++;
         $display("FAIL reset_cnt: got %0d required 0", conflict_cnt);
      end
   endtask

   task automatic test_single_read();
      logic [LINE_W-1:0] pat;
      pat = {32{8'hA5}};
      step();
      i_read = 1; i_address = 32'h60;
      @(negedge clk);
      checks++;
      if (m_read !== 1'b0) begin
         errors++; $display("FAIL single_latency: got m_read=%b required 0", m_read);
      end
      step();
      @(negedge clk);
      checks++;
      if (m_read !== 1'b1 || m_address !== 32'h60) begin
         errors++; $display("FAIL single_request: got m_read=%b addr=%0h required 1/60", m_read, m_address);
      end
      step();
      m_resp = 1; m_rdata = pat;
      @(negedge clk);
      checks++;
      if (i_resp !== 1'b1 || d_resp !== 1'b0) begin
         errors++; $display("FAIL single_resp: got i_resp=%b d_resp=%b required 1/0", i_resp, d_resp);
      end
      checks++;
      if (i_rdata !== pat) begin
         errors++; $display("FAIL single_rdata: got %h required %h", i_rdata, pat);
      end
      step();
      m_resp = 0; i_read = 0;
      @(negedge clk);
      checks++;
      if (m_read !== 1'b0 || i_resp !== 1'b0) begin
         errors++; $display("FAIL single_idle: got m_read=%b i_resp=%b required 0/0", m_read, i_resp);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      i_read = 1; i_address = 32'h100;
      d_write = 1; d_address = 32'h200; d_wdata = 256'hBEEF;
      step();
      @(negedge clk);
      checks++;
      if (m_read !== 1'b1 || m_write !== 1'b0 || m_address !== 32'h100) begin
         errors++; $display("FAIL simul_first_grant: got rd=%b wr=%b addr=%0h required 1/0/100", m_read, m_write, m_address);
      end
      step();
      step();
      m_resp = 1;
      @(negedge clk);
      checks++;
      if (i_resp !== 1'b1 || d_resp !== 1'b0) begin
         errors++; $display("FAIL simul_iresp: got i_resp=%b d_resp=%b required 1/0", i_resp, d_resp);
      end
      step();
      m_resp = 0; i_read = 0;
      @(negedge clk);
      checks++;
      if (m_write !== 1'b1 || m_read !== 1'b0 || m_address !== 32'h200) begin
         errors++; $display("FAIL simul_second_grant: got rd=%b wr=%b addr=%0h required 0/1/200", m_read, m_write, m_address);
      end
      checks++;
      if (conflict_cnt !== 32'd3) begin
         errors++; $display("FAIL simul_conflict: got %0d required 3", conflict_cnt);
      end
      step();
      m_resp = 1;
      @(negedge clk);
      checks++;
      if (d_resp !== 1'b1 || i_resp !== 1'b0) begin
         errors++; $display("FAIL simul_dresp: got d_resp=%b i_resp=%b required 1/0", d_resp, i_resp);
      end
      step();
      m_resp = 0; d_write = 0;
   endtask

   task automatic test_alternation();
      bit exp_i;
      bit ok;
      do_reset();
      i_read = 1; i_address = 32'h1000;
      d_write = 1; d_address = 32'h2000;
      for (int t = 0; t < 10; t++) begin
         exp_i = (t % 2 == 0);
         step();
         m_resp = 0;
         @(negedge clk);
         ok = exp_i ? (m_read === 1'b1 && m_write === 1'b0 && m_address === 32'h1000)
                    : (m_write === 1'b1 && m_read === 1'b0 && m_address === 32'h2000);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL alt_grant_%0d: got rd=%b wr=%b addr=%0h required grant to %s", t, m_read, m_write, m_address, exp_i ? "icache" : "dcache");
         end
         step();
         m_resp = 1;
         @(negedge clk);
         checks++;
         if (i_resp !== exp_i || d_resp !== !exp_i) begin
            errors++;
            $display("FAIL alt_resp_%0d: got i_resp=%b d_resp=%b required %b/%b", t, i_resp, d_resp, exp_i, !exp_i);
         end
      end
      step();
      m_resp = 0; i_read = 0; d_write = 0;
      @(negedge clk);
      checks++;
      if (conflict_cnt !== 32'd20) begin
         errors++; $display("FAIL alt_conflict: got %0d required 20", conflict_cnt);
      end
      step();
   endtask

   task automatic test_write_precedence();
      do_reset();
      d_read = 1; d_write = 1; d_address = 32'h300; d_wdata = 256'h1234;
      step();
      @(negedge clk);
      checks++;
      if (m_write !== 1'b1 || m_read !== 1'b0 || m_wdata !== 256'h1234 || m_address !== 32'h300) begin
         errors++; $display("FAIL precedence: got rd=%b wr=%b wdata=%0h addr=%0h required 0/1/1234/300", m_read, m_write, m_wdata, m_address);
      end
      step();
      m_resp = 1;
      @(negedge clk);
      checks++;
      if (d_resp !== 1'b1) begin
         errors++; $display("FAIL precedence_resp: got d_resp=%b required 1", d_resp);
      end
      step();
      m_resp = 0; d_read = 0; d_write = 0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      d_write = 1; d_address = 32'h500; i_address = 32'h600;
      step();
      i_read = 1;
      @(negedge clk);
      checks++;
      if (m_write !== 1'b1) begin
         errors++; $display("FAIL midrst_setup: got m_write=%b required 1", m_write);
      end
      step();
      @(negedge clk);
      checks++;
      if (conflict_cnt !== 32'd1) begin
         errors++; $display("FAIL midrst_cnt_before: got %0d required 1", conflict_cnt);
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if (m_write !== 1'b0 || m_read !== 1'b0) begin
         errors++; $display("FAIL midrst_async: got rd=%b wr=%b required 0/0", m_read, m_write);
      end
      checks++;
      if (conflict_cnt !== 32'd0) begin
         errors++; $display("FAIL midrst_cnt: got %0d required 0", conflict_cnt);
      end
      step();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (m_write !== 1'b0 || m_read !== 1'b0) begin
         errors++; $display("FAIL midrst_idle: got rd=%b wr=%b required 0/0", m_read, m_write);
      end
      step();
      @(negedge clk);
      checks++;
      if (m_read !== 1'b1 || m_write !== 1'b0 || m_address !== 32'h600) begin
         errors++; $display("FAIL midrst_tie: got rd=%b wr=%b addr=%0h required 1/0/600", m_read, m_write, m_address);
      end
      step();
      i_read = 0; d_write = 0;
      step();
   endtask

   task automatic test_abandon_stray();
      do_reset();
      d_read = 1; d_address = 32'h400;
      step();
      @(negedge clk);
      checks++;
      if (m_read !== 1'b1 || m_address !== 32'h400) begin
         errors++; $display("FAIL abandon_setup: got m_read=%b addr=%0h required 1/400", m_read, m_address);
      end
      step();
      d_read = 0;
      @(negedge clk);
      checks++;
      if (m_read !== 1'b0) begin
         errors++; $display("FAIL abandon_drop: got m_read=%b required 0", m_read);
      end
      step();
      m_resp = 1;
      @(negedge clk);
      checks++;
      if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
         errors++; $display("FAIL stray_resp: got i_resp=%b d_resp=%b required 0/0", i_resp, d_resp);
      end
      step();
      m_resp = 0; d_read = 1;
      @(negedge clk);
      checks++;
      if (m_read !== 1'b0) begin
         errors++; $display("FAIL stray_still_idle: got m_read=%b required 0", m_read);
      end
      step();
      @(negedge clk);
      checks++;
      if (m_read !== 1'b1) begin
         errors++; $display("FAIL stray_regrant: got m_read=%b required 1", m_read);
      end
      step();
      d_read = 0;
      step();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_simultaneous();
      test_alternation();
      test_write_precedence();
      test_reset_mid();
      test_abandon_stray();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
